// File: rtl/rtc_keyset_if.sv
// Keypad, alarm and time-display bundle for rtc_keyset.
// The DUT takes the slave side; the driver of keys takes master.
interface rtc_keyset_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       tick;
  logic [4:0] edit_hour;
  logic [5:0] edit_min;
  logic [5:0] edit_sec;
  logic [3:0] edit_field;
  logic       alarm_hit;

  modport master (
    output key_valid, key_code,
    output alarm_hour, alarm_min,
    input  hour, min, sec, tick,
    input  edit_hour, edit_min, edit_sec,
    input  edit_field, alarm_hit
  );

  modport slave (
    input  key_valid, key_code,
    input  alarm_hour, alarm_min,
    output hour, min, sec, tick,
    output edit_hour, edit_min, edit_sec,
    output edit_field, alarm_hit
  );
endinterface

// File: rtl/rtc_keyset.sv
// hh:mm:ss keeper with keypad set sequence and shadow registers.
// Optional alarm pulse enabled by defining RTC_ALARM_EN.
module rtc_keyset #(
  parameter int CLK_HZ = 100000000,
  parameter bit H24    = 1'b0
) (
  input logic         clk,
  input logic         rst,
  rtc_keyset_if.slave bus
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [4:0] HMAX = H24 ? 5'd23 : 5'd11;

  typedef enum logic [3:0] {
    RUN   = 4'b0001,
    SET_H = 4'b0010,
    SET_M = 4'b0100,
    SET_S = 4'b1000
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_pre;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_tick;
  logic [4:0]    r_eh;
  logic [5:0]    r_em;
  logic [5:0]    r_es;

  logic w_dig;
  logic w_ent;
  logic w_set;
  logic w_esc;
  logic w_adv;
  logic w_commit;

  logic [4:0] w_nhour;
  logic [5:0] w_nmin;
  logic [5:0] w_nsec;
  logic       w_sec_wrap;
  logic       w_min_wrap;

  logic [5:0] w_dh;
  logic [5:0] w_dm;
  logic [5:0] w_ds;

  // 10-bit intermediate: v*10+d reaches 599 for a 59 minute field
  function automatic logic [5:0] f_digit(
    input logic [5:0] v,
    input logic [3:0] d,
    input logic [5:0] m
  );
    logic [9:0] w_t;
    w_t = 10'(v) * 10'd10 + 10'(d);
    if (w_t <= 10'(m))
      f_digit = w_t[5:0];
    else if (6'(d) <= m)
      f_digit = 6'(d);
    else
      f_digit = v;
  endfunction

  assign w_dig = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_ent = bus.key_valid && (bus.key_code == 4'hA);
  assign w_set = bus.key_valid && (bus.key_code == 4'hB);
  assign w_esc = bus.key_valid && (bus.key_code == 4'hC);

  assign w_adv    = (r_pre == PMAX);
  assign w_commit = w_ent && (r_state == SET_S);

  assign w_sec_wrap = (r_sec == 6'd59);
  assign w_min_wrap = (r_min == 6'd59);

  assign w_nsec = w_sec_wrap ? 6'd0 : r_sec + 6'd1;

  always_comb begin
    w_nmin  = r_min;
    w_nhour = r_hour;
    if (w_sec_wrap) begin
      w_nmin = w_min_wrap ? 6'd0 : r_min + 6'd1;
      if (w_min_wrap)
        w_nhour = (r_hour == HMAX) ? 5'd0 : r_hour + 5'd1;
    end
  end

  assign w_dh = f_digit({1'b0, r_eh}, bus.key_code, {1'b0, HMAX});
  assign w_dm = f_digit(r_em, bus.key_code, 6'd59);
  assign w_ds = f_digit(r_es, bus.key_code, 6'd59);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN: begin
        if (w_set)
          w_next = SET_H;
      end
      SET_H, SET_M, SET_S: begin
        unique case (1'b1)
          w_set: w_next = SET_H;
          w_esc: w_next = RUN;
          w_ent: begin
            unique case (r_state)
              SET_H:   w_next = SET_M;
              SET_M:   w_next = SET_S;
              default: w_next = RUN;
            endcase
          end
          default: w_next = r_state;
        endcase
      end
      default: w_next = RUN;
    endcase
  end

  // B reloads from live time in every state, digits edit the active field
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eh <= '0;
      r_em <= '0;
      r_es <= '0;
    end else if (w_set) begin
      r_eh <= r_hour;
      r_em <= r_min;
      r_es <= r_sec;
    end else if (w_dig) begin
      unique case (r_state)
        SET_H:   r_eh <= w_dh[4:0];
        SET_M:   r_em <= w_dm;
        SET_S:   r_es <= w_ds;
        default: ;
      endcase
    end
  end

  // Commit outranks a coincident advance and restarts the second
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_tick <= 1'b0;
    end else if (w_commit) begin
      r_pre  <= '0;
      r_hour <= r_eh;
      r_min  <= r_em;
      r_sec  <= r_es;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_adv ? '0 : r_pre + 1'b1;
      r_tick <= w_adv;
      if (w_adv) begin
        r_hour <= w_nhour;
        r_min  <= w_nmin;
        r_sec  <= w_nsec;
      end
    end
  end

  assign bus.hour       = r_hour;
  assign bus.min        = r_min;
  assign bus.sec        = r_sec;
  assign bus.tick       = r_tick;
  assign bus.edit_hour  = r_eh;
  assign bus.edit_min   = r_em;
  assign bus.edit_sec   = r_es;
  assign bus.edit_field = r_state;

`ifdef RTC_ALARM_EN
  logic r_alarm;
  logic w_amatch;
  logic w_unused;

  // next time is always in range, so bad alarm inputs cannot match
  assign w_amatch = (w_nhour == bus.alarm_hour) &&
                    (w_nmin == bus.alarm_min) &&
                    (w_nsec == 6'd0);

  always_ff @(posedge clk) begin
    if (rst)
      r_alarm <= 1'b0;
    else
      r_alarm <= w_adv && !w_commit && w_amatch;
  end

  assign bus.alarm_hit = r_alarm;
  assign w_unused      = w_dh[5];
`else
  logic w_unused;

  assign bus.alarm_hit = 1'b0;
  assign w_unused      = ^{w_dh[5], bus.alarm_hour, bus.alarm_min};
`endif

endmodule

// File: tb/tb_rtc_keyset.sv
// Bench for rtc_keyset: directed tables and sequences plus a
// randomized run against a seconds-count model, H24=0 and H24=1 side by side.
module tb_rtc_keyset;

  localparam int CLK = 4;
  localparam int KA  = 10;
  localparam int KB  = 11;
  localparam int KC  = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rtc_keyset_if b0();
  rtc_keyset_if b1();

  rtc_keyset #(.CLK_HZ(CLK), .H24(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  rtc_keyset #(.CLK_HZ(CLK), .H24(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int a_h = 0;
  int a_m = 0;

  int hmax[2] = '{11, 23};
  int m_t[2];
  int m_e[2];
  int m_mode[2];
  int m_sh[2];
  int m_sm[2];
  int m_ss[2];
  bit m_tk[2];
  bit m_al[2];

  typedef struct {
    int code;
    int fld;
    int eh0;
    int eh1;
    int em;
    int es;
  } vec_t;

  vec_t tv[10];

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dig(int v, int d, int m);
    if (v * 10 + d <= m) return v * 10 + d;
    if (d <= m) return d;
    return v;
  endfunction

  // Live time held as seconds since midnight; m_e counts cycles since epoch
  function automatic void mstep(int i, bit r, bit v, int c);
    int n;
    int ot;
    bit adv;
    bit com;
    if (r) begin
      m_t[i] = 0; m_e[i] = 0; m_mode[i] = 0;
      m_sh[i] = 0; m_sm[i] = 0; m_ss[i] = 0;
      m_tk[i] = 0; m_al[i] = 0;
      return;
    end
    n   = (hmax[i] + 1) * 3600;
    ot  = m_t[i];
    adv = (m_e[i] % CLK) == CLK - 1;
    com = v && m_mode[i] == 3 && c == KA;
    if (v) begin
      if (c == KB) begin
        m_sh[i] = ot / 3600;
        m_sm[i] = (ot / 60) % 60;
        m_ss[i] = ot % 60;
        m_mode[i] = 1;
      end else if (m_mode[i] != 0) begin
        if (c == KC)
          m_mode[i] = 0;
        else if (c == KA)
          m_mode[i] = (m_mode[i] == 3) ? 0 : m_mode[i] + 1;
        else if (c <= 9) begin
          case (m_mode[i])
            1: m_sh[i] = dig(m_sh[i], c, hmax[i]);
            2: m_sm[i] = dig(m_sm[i], c, 59);
            default: m_ss[i] = dig(m_ss[i], c, 59);
          endcase
        end
      end
    end
    if (com) begin
      m_t[i] = m_sh[i] * 3600 + m_sm[i] * 60 + m_ss[i];
      m_e[i] = 0;
      m_tk[i] = 0;
      m_al[i] = 0;
    end else begin
      m_e[i] = m_e[i] + 1;
      m_tk[i] = adv;
      if (adv) m_t[i] = (ot + 1) % n;
      m_al[i] = adv && a_h <= hmax[i] && a_m <= 59 &&
                m_t[i] == a_h * 3600 + a_m * 60;
    end
  endfunction

  task automatic check_one(int i, int h, int mi, int s, int tk,
                           int eh, int em, int es, int fld, int al);
    int exp_al;
`ifdef RTC_ALARM_EN
    exp_al = m_al[i];
`else
    exp_al = 0;
`endif
    chk($sformatf("u%0d.hour", i), h, m_t[i] / 3600);
    chk($sformatf("u%0d.min", i), mi, (m_t[i] / 60) % 60);
    chk($sformatf("u%0d.sec", i), s, m_t[i] % 60);
    chk($sformatf("u%0d.tick", i), tk, m_tk[i]);
    chk($sformatf("u%0d.edit_hour", i), eh, m_sh[i]);
    chk($sformatf("u%0d.edit_min", i), em, m_sm[i]);
    chk($sformatf("u%0d.edit_sec", i), es, m_ss[i]);
    chk($sformatf("u%0d.edit_field", i), fld, 1 << m_mode[i]);
    chk($sformatf("u%0d.alarm_hit", i), al, exp_al);
  endtask

  task automatic step(bit r, bit v, int c);
    rst = r;
    b0.key_valid = v;  b1.key_valid = v;
    b0.key_code = 4'(c); b1.key_code = 4'(c);
    b0.alarm_hour = 5'(a_h); b1.alarm_hour = 5'(a_h);
    b0.alarm_min = 6'(a_m); b1.alarm_min = 6'(a_m);
    @(posedge clk);
    mstep(0, r, v, c);
    mstep(1, r, v, c);
    #1;
    check_one(0, b0.hour, b0.min, b0.sec, b0.tick, b0.edit_hour,
              b0.edit_min, b0.edit_sec, b0.edit_field, b0.alarm_hit);
    check_one(1, b1.hour, b1.min, b1.sec, b1.tick, b1.edit_hour,
              b1.edit_min, b1.edit_sec, b1.edit_field, b1.alarm_hit);
  endtask

  task automatic press(int c);
    step(1'b0, 1'b1, c);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0);
  endtask

  initial begin
    tv[0] = '{KB, 2, 0, 0, 0, 0};
    tv[1] = '{2, 2, 2, 2, 0, 0};
    tv[2] = '{3, 2, 3, 23, 0, 0};
    tv[3] = '{KA, 4, 3, 23, 0, 0};
    tv[4] = '{5, 4, 3, 23, 5, 0};
    tv[5] = '{9, 4, 3, 23, 59, 0};
    tv[6] = '{KA, 8, 3, 23, 59, 0};
    tv[7] = '{0, 8, 3, 23, 59, 0};
    tv[8] = '{7, 8, 3, 23, 59, 7};
    tv[9] = '{KA, 1, 3, 23, 59, 7};

    do_reset();
    do_reset();
    chk("rst.field", b0.edit_field, 1);
    chk("rst.hour", b1.hour, 0);
    chk("rst.tick", b0.tick, 0);
    chk("rst.alarm", b0.alarm_hit, 0);

    for (int k = 0; k < 10; k++) begin
      press(tv[k].code);
      chk($sformatf("tbl%0d.field", k), b1.edit_field, tv[k].fld);
      chk($sformatf("tbl%0d.eh0", k), b0.edit_hour, tv[k].eh0);
      chk($sformatf("tbl%0d.eh1", k), b1.edit_hour, tv[k].eh1);
      chk($sformatf("tbl%0d.em", k), b1.edit_min, tv[k].em);
      chk($sformatf("tbl%0d.es", k), b1.edit_sec, tv[k].es);
    end
    chk("h24.hour", b1.hour, 23);
    chk("h24.min", b1.min, 59);
    chk("h24.sec", b1.sec, 7);
    chk("h12.hour", b0.hour, 3);
    for (int k = 0; k < CLK - 1; k++) begin
      idle(1);
      chk("h24.notick", b1.tick, 0);
    end
    idle(1);
    chk("h24.tick", b1.tick, 1);
    chk("h24.sec8", b1.sec, 8);

    do_reset();
    press(KB); press(1); press(1); press(KA); press(5);
    press(9); press(KA); press(5); press(9); press(KA);
    chk("roll.h", b0.hour, 11);
    chk("roll.s", b0.sec, 59);
    for (int k = 0; k < CLK - 1; k++) begin
      idle(1);
      chk("roll.notick", b0.tick, 0);
    end
    idle(1);
    chk("roll.tick", b0.tick, 1);
    chk("roll.h0", b0.hour, 0);
    chk("roll.m0", b0.min, 0);
    chk("roll.s0", b0.sec, 0);
    chk("roll.h24", b1.hour, 12);
    for (int k = 0; k < CLK - 1; k++) begin
      idle(1);
      chk("roll.hold", b0.sec, 0);
      chk("roll.tick0", b0.tick, 0);
    end
    idle(1);
    chk("roll.s1", b0.sec, 1);
    chk("roll.tick1", b0.tick, 1);

    do_reset();
    press(KB); press(1); press(5);
    chk("clamp.h5", b0.edit_hour, 5);
    press(1); press(1);
    chk("clamp.h11", b0.edit_hour, 11);
    press(KA); press(7); press(7);
    chk("clamp.m7", b0.edit_min, 7);

    do_reset();
    press(KB); press(9); press(KA); press(KC);
    chk("esc.field", b0.edit_field, 1);
    chk("esc.eh", b0.edit_hour, 9);
    idle(4);
    chk("esc.sec", b0.sec, 2);
    chk("esc.hour", b0.hour, 0);

    do_reset();
    press(KB); press(4); press(KA); press(KA);
    idle(3);
    press(KA);
    chk("sim.hour", b0.hour, 4);
    chk("sim.sec", b0.sec, 0);
    chk("sim.tick", b0.tick, 0);
    chk("sim.field", b0.edit_field, 1);
    press(KB); press(KA);
    chk("sim.setm", b0.edit_field, 4);
    step(1'b1, 1'b1, 5);
    chk("rstm.field", b0.edit_field, 1);
    chk("rstm.hour", b0.hour, 0);
    chk("rstm.eh", b0.edit_hour, 0);
    chk("rstm.tick", b0.tick, 0);

`ifdef RTC_ALARM_EN
    do_reset();
    a_h = 1;
    a_m = 2;
    press(KB); press(1); press(KA); press(1); press(KA);
    press(5); press(9); press(KA);
    chk("alm.sec", b0.sec, 59);
    for (int k = 0; k < CLK - 1; k++) begin
      idle(1);
      chk("alm.quiet", b0.alarm_hit, 0);
    end
    idle(1);
    chk("alm.hit", b0.alarm_hit, 1);
    chk("alm.tick", b0.tick, 1);
    chk("alm.min", b0.min, 2);
    press(KB); press(KA); press(KA); press(KA);
    chk("almc.min", b0.min, 2);
    chk("almc.sec", b0.sec, 0);
    chk("almc.hit", b0.alarm_hit, 0);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int k;
      int c;
      bit r;
      bit v;
      if (n % 100 == 0) begin
        a_h = $urandom_range(0, 31);
        a_m = $urandom_range(0, 63);
      end
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 1) == 1);
      k = $urandom_range(0, 19);
      if (k < 10) c = k;
      else if (k < 14) c = KA;
      else if (k < 15) c = KB;
      else if (k < 16) c = KC;
      else c = $urandom_range(13, 15);
      step(r, v, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
